// File: rtl/sequenciador_transmissao_bcd_pkg.sv
// rtl/sequenciador_transmissao_bcd_pkg.sv - shared state encoding and sizing helpers for the BCD transmit sequencer
package sequenciador_transmissao_bcd_pkg;

    localparam int DB_ESTADO_W = 4;

    // Encoding is exported on db_estado, so the numeric values are fixed.
    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL   = 4'd0,
        REGISTRA  = 4'd1,
        TRANSMITE = 4'd2,
        ESPERA    = 4'd3,
        PROXIMO   = 4'd4,
        FINAL     = 4'd5
    } estado_t;

    // Width of a counter that must hold 0..num_digitos-1, never narrower than one bit.
    function automatic int largura_contador(input int num_digitos);
        return (num_digitos <= 2) ? 1 : $clog2(num_digitos);
    endfunction

endpackage

// File: rtl/sequenciador_transmissao_bcd_contador_digitos.sv
// rtl/sequenciador_transmissao_bcd_contador_digitos.sv - modulo-N digit counter with clear, enable and last-value flag
module sequenciador_transmissao_bcd_contador_digitos #(
    parameter int MODULO  = 4,
    parameter int LARGURA = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               habilita,
    output logic [LARGURA-1:0] valor,
    output logic               ultimo
);

    assign ultimo = (valor == LARGURA'(MODULO - 1));

    // Clear has priority over counting; the count wraps after the last digit.
    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            valor <= '0;
        end else if (habilita) begin
            valor <= ultimo ? '0 : valor + LARGURA'(1);
        end
    end

endmodule

// File: rtl/sequenciador_transmissao_bcd.sv
// rtl/sequenciador_transmissao_bcd.sv - sends a packed-BCD word digit by digit, MSD first, through a BCD-to-ASCII datapath
module sequenciador_transmissao_bcd
    import sequenciador_transmissao_bcd_pkg::*;
#(
    parameter int NUM_BYTES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   partida,
    input  logic [8*NUM_BYTES-1:0] dados_bcd,
    input  logic                   pronto_transmissao_bcd,
    output logic [7:0]             bcd,
    output logic                   seletor_valor,
    output logic                   inicio_transmissao_bcd,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [DB_ESTADO_W-1:0] db_estado
);

    localparam int NUM_DIGITOS = 2 * NUM_BYTES;
    localparam int CONT_W      = largura_contador(NUM_DIGITOS);

    estado_t                  estado;
    logic [8*NUM_BYTES-1:0]   dados_reg;
    logic [CONT_W-1:0]        digito;
    logic                     ultimo_digito;
    logic                     limpa_contador;
    logic                     avanca_contador;
    logic                     inicio_reg;
    logic                     ocupado_reg;
    logic                     pronto_reg;

    assign limpa_contador  = (estado == REGISTRA);
    assign avanca_contador = (estado == PROXIMO);

    sequenciador_transmissao_bcd_contador_digitos #(
        .MODULO  (NUM_DIGITOS),
        .LARGURA (CONT_W)
    ) u_contador_digitos (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa_contador),
        .habilita (avanca_contador),
        .valor    (digito),
        .ultimo   (ultimo_digito)
    );

    // Control FSM: outputs are registered alongside the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= INICIAL;
            dados_reg   <= '0;
            inicio_reg  <= 1'b0;
            ocupado_reg <= 1'b0;
            pronto_reg  <= 1'b0;
        end else begin
            inicio_reg <= 1'b0;
            pronto_reg <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (partida) begin
                        estado      <= REGISTRA;
                        ocupado_reg <= 1'b1;
                    end
                end
                REGISTRA: begin
                    dados_reg  <= dados_bcd;
                    estado     <= TRANSMITE;
                    inicio_reg <= 1'b1;
                end
                TRANSMITE: begin
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (pronto_transmissao_bcd) begin
                        if (ultimo_digito) begin
                            estado      <= FINAL;
                            pronto_reg  <= 1'b1;
                            ocupado_reg <= 1'b0;
                        end else begin
                            estado <= PROXIMO;
                        end
                    end
                end
                PROXIMO: begin
                    estado     <= TRANSMITE;
                    inicio_reg <= 1'b1;
                end
                FINAL: begin
                    estado <= INICIAL;
                end
                default: begin
                    estado      <= INICIAL;
                    ocupado_reg <= 1'b0;
                end
            endcase
        end
    end

    // Digit d selects byte NUM_BYTES-1-d/2; even digits are the high nibble.
    always_comb begin
        bcd = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (int'(digito >> 1) == (NUM_BYTES - 1 - i)) begin
                bcd = dados_reg[8*i +: 8];
            end
        end
    end

    // Nibble select is forced low when idle so reset leaves every output at zero.
    assign seletor_valor          = ocupado_reg & ~digito[0];
    assign inicio_transmissao_bcd = inicio_reg;
    assign ocupado                = ocupado_reg;
    assign pronto                 = pronto_reg;
    assign db_estado              = estado;

endmodule

// File: tb/tb_sequenciador_transmissao_bcd.sv
// tb/tb_sequenciador_transmissao_bcd.sv - randomized self-checking bench for the BCD transmit sequencer
module tb_sequenciador_transmissao_bcd;

    typedef struct {
        int         ciclo;
        logic [7:0] bcd;
        logic       sel;
    } ev_t;

    typedef struct {
        int         ciclo;
        logic       ini;
        logic [7:0] bcd;
        logic       sel;
        logic       ocu;
        logic       pro;
        logic [3:0] est;
    } am_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        partida2, partida1;
    logic [15:0] dados2;
    logic [7:0]  dados1;
    logic        ack2, ack1, forca2;
    logic [7:0]  bcd2, bcd1;
    logic        sel2, sel1, ini2, ini1, ocu2, ocu1, pro2, pro1;
    logic [3:0]  est2, est1;

    am_t log2[$];
    am_t log1[$];
    ev_t esp[$];
    int  esp_pr[$];
    int  atraso2[16];
    int  idx2, cnt2, cnt1;
    int  ciclo  = 0;
    int  checks = 0;
    int  errors = 0;

    sequenciador_transmissao_bcd #(.NUM_BYTES(2)) dut2 (
        .clock(clock), .reset(reset), .partida(partida2), .dados_bcd(dados2),
        .pronto_transmissao_bcd(ack2), .bcd(bcd2), .seletor_valor(sel2),
        .inicio_transmissao_bcd(ini2), .ocupado(ocu2), .pronto(pro2), .db_estado(est2)
    );

    sequenciador_transmissao_bcd #(.NUM_BYTES(1)) dut1 (
        .clock(clock), .reset(reset), .partida(partida1), .dados_bcd(dados1),
        .pronto_transmissao_bcd(ack1), .bcd(bcd1), .seletor_valor(sel1),
        .inicio_transmissao_bcd(ini1), .ocupado(ocu1), .pronto(pro1), .db_estado(est1)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        ciclo++;
    end

    // Observer and datapath stand-in for the two-byte instance.
    initial begin
        ack2 = 1'b0; cnt2 = 0; idx2 = 0;
        forever begin
            @(negedge clock);
            log2.push_back('{ciclo, ini2, bcd2, sel2, ocu2, pro2, est2});
            ack2 = forca2;
            if (cnt2 > 0) begin
                cnt2--;
                if (cnt2 == 0) ack2 = 1'b1;
            end
            if (ini2 === 1'b1) begin
                cnt2 = atraso2[idx2 % 16];
                idx2++;
            end
        end
    end

    // Observer and immediate-ack datapath stand-in for the one-byte instance.
    initial begin
        ack1 = 1'b0; cnt1 = 0;
        forever begin
            @(negedge clock);
            log1.push_back('{ciclo, ini1, bcd1, sel1, ocu1, pro1, est1});
            ack1 = 1'b0;
            if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0) ack1 = 1'b1;
            end
            if (ini1 === 1'b1) cnt1 = 1;
        end
    end

    task automatic espera_ciclo;
        @(posedge clock);
        #2;
    endtask

    // Reference: partida in cycle p, first start at p+2, each ack d cycles after its start,
    // next start 2 cycles after an ack, done pulse 1 cycle after the last ack.
    function automatic void modela(input int n, input logic [63:0] w, input int p, input int atr[16]);
        int t;
        t = p + 2;
        for (int d = 0; d < 2 * n; d++) begin
            logic [63:0] sh;
            sh = w >> (8 * (n - 1 - d / 2));
            esp.push_back('{t, sh[7:0], ((d % 2) == 0) ? 1'b1 : 1'b0});
            if (d == 2 * n - 1) esp_pr.push_back(t + atr[d] + 1);
            else t = t + atr[d] + 2;
        end
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) espera_ciclo;
        @(negedge clock);
        checks++;
        if ({ini2, ocu2, pro2, sel2, bcd2} !== 12'h000) begin
            errors++;
            $display("FAIL reset_saidas_n2: obtido ini=%b ocu=%b pro=%b sel=%b bcd=%h, esperado todos 0", ini2, ocu2, pro2, sel2, bcd2);
        end
        checks++;
        if (est2 !== 4'd0) begin errors++; $display("FAIL reset_estado_n2: obtido %0d esperado 0", est2); end
        checks++;
        if ({ini1, ocu1, pro1, sel1, bcd1} !== 12'h000) begin
            errors++;
            $display("FAIL reset_saidas_n1: obtido ini=%b ocu=%b pro=%b sel=%b bcd=%h, esperado todos 0", ini1, ocu1, pro1, sel1, bcd1);
        end
        checks++;
        if (est1 !== 4'd0) begin errors++; $display("FAIL reset_estado_n1: obtido %0d esperado 0", est1); end
        espera_ciclo;
        reset = 1'b0;
        repeat (2) espera_ciclo;
    endtask

    // Scenarios: 0x1234 with slow acks, 0x0909 with immediate acks, busy re-start, random words.
    task automatic test_palavras;
        for (int r = 0; r < 6; r++) begin
            logic [15:0] w;
            int p, n_ini, n_pro, ocu_err;
            w = (r == 0 || r == 2) ? 16'h1234 : (r == 1) ? 16'h0909 : 16'($urandom);
            for (int k = 0; k < 16; k++)
                atraso2[k] = (r == 0) ? 10 : (r == 1) ? 1 : (r == 2) ? 4 : int'($urandom_range(1, 12));
            idx2 = 0;
            esp.delete(); esp_pr.delete();
            espera_ciclo;
            log2.delete();
            p = ciclo;
            modela(2, 64'(w), p, atraso2);
            dados2 = w; partida2 = 1'b1;
            espera_ciclo;
            partida2 = 1'b0;
            while (ciclo < esp_pr[0] + 3) begin
                if (r == 2 && ciclo == esp[1].ciclo + 1) begin
                    partida2 = 1'b1; dados2 = 16'h5555;
                end else begin
                    partida2 = 1'b0;
                end
                espera_ciclo;
            end
            partida2 = 1'b0;
            n_ini = 0; n_pro = 0; ocu_err = 0;
            foreach (log2[i]) begin
                if (log2[i].ini === 1'b1) begin
                    if (n_ini < esp.size()) begin
                        checks++;
                        if (log2[i].ciclo != esp[n_ini].ciclo || log2[i].bcd !== esp[n_ini].bcd || log2[i].sel !== esp[n_ini].sel) begin
                            errors++;
                            $display("FAIL palavra%0d_digito%0d: obtido ciclo=%0d bcd=%h sel=%b, esperado ciclo=%0d bcd=%h sel=%b",
                                     r, n_ini, log2[i].ciclo, log2[i].bcd, log2[i].sel, esp[n_ini].ciclo, esp[n_ini].bcd, esp[n_ini].sel);
                        end
                    end
                    n_ini++;
                end
                if (log2[i].pro === 1'b1) begin
                    if (n_pro == 0) begin
                        checks++;
                        if (log2[i].ciclo != esp_pr[0]) begin
                            errors++;
                            $display("FAIL palavra%0d_pronto_ciclo: obtido %0d esperado %0d", r, log2[i].ciclo, esp_pr[0]);
                        end
                    end
                    n_pro++;
                end
                if (log2[i].ocu !== ((log2[i].ciclo > p && log2[i].ciclo < esp_pr[0]) ? 1'b1 : 1'b0)) ocu_err++;
            end
            checks++;
            if (n_ini != esp.size()) begin errors++; $display("FAIL palavra%0d_num_inicio: obtido %0d esperado %0d", r, n_ini, esp.size()); end
            checks++;
            if (n_pro != 1) begin errors++; $display("FAIL palavra%0d_num_pronto: obtido %0d esperado 1", r, n_pro); end
            checks++;
            if (ocu_err != 0) begin errors++; $display("FAIL palavra%0d_ocupado: %0d ciclos errados, esperado 0", r, ocu_err); end
        end
    endtask

    task automatic test_reset_meio;
        int p, rc, n_extra, n_ini;
        for (int k = 0; k < 16; k++) atraso2[k] = 5;
        idx2 = 0;
        esp.delete(); esp_pr.delete();
        espera_ciclo;
        p = ciclo;
        modela(2, 64'h1234, p, atraso2);
        dados2 = 16'h1234; partida2 = 1'b1;
        espera_ciclo;
        partida2 = 1'b0;
        rc = esp[2].ciclo + 2;
        while (ciclo < rc) espera_ciclo;
        reset = 1'b1;
        espera_ciclo;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({ini2, ocu2, pro2, sel2, bcd2} !== 12'h000 || est2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_meio_saidas: obtido ini=%b ocu=%b pro=%b sel=%b bcd=%h est=%0d, esperado todos 0",
                     ini2, ocu2, pro2, sel2, bcd2, est2);
        end
        n_extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (ini2 === 1'b1 || pro2 === 1'b1) n_extra++;
        end
        checks++;
        if (n_extra != 0) begin errors++; $display("FAIL reset_meio_sem_inicio: obtido %0d pulsos esperado 0", n_extra); end
        for (int k = 0; k < 16; k++) atraso2[k] = 2;
        idx2 = 0;
        esp.delete(); esp_pr.delete();
        espera_ciclo;
        log2.delete();
        p = ciclo;
        modela(2, 64'h0001, p, atraso2);
        dados2 = 16'h0001; partida2 = 1'b1;
        espera_ciclo;
        partida2 = 1'b0;
        while (ciclo < esp_pr[0] + 3) espera_ciclo;
        n_ini = 0;
        foreach (log2[i]) begin
            if (log2[i].ini === 1'b1) begin
                if (n_ini < esp.size()) begin
                    checks++;
                    if (log2[i].ciclo != esp[n_ini].ciclo || log2[i].bcd !== esp[n_ini].bcd || log2[i].sel !== esp[n_ini].sel) begin
                        errors++;
                        $display("FAIL pos_reset_digito%0d: obtido ciclo=%0d bcd=%h sel=%b, esperado ciclo=%0d bcd=%h sel=%b",
                                 n_ini, log2[i].ciclo, log2[i].bcd, log2[i].sel, esp[n_ini].ciclo, esp[n_ini].bcd, esp[n_ini].sel);
                    end
                end
                n_ini++;
            end
        end
        checks++;
        if (n_ini != 4) begin errors++; $display("FAIL pos_reset_num_inicio: obtido %0d esperado 4", n_ini); end
    endtask

    // partida held for 20 cycles: every return to idle inside that window begins another word.
    task automatic test_um_byte;
        int p, inicio_palavra, n_ini, n_pro;
        int um[16];
        for (int k = 0; k < 16; k++) um[k] = 1;
        esp.delete(); esp_pr.delete();
        espera_ciclo;
        log1.delete();
        p = ciclo;
        inicio_palavra = p;
        while (inicio_palavra <= p + 19) begin
            modela(1, 64'h97, inicio_palavra, um);
            inicio_palavra = esp_pr[esp_pr.size() - 1] + 1;
        end
        dados1 = 8'h97; partida1 = 1'b1;
        repeat (20) espera_ciclo;
        partida1 = 1'b0;
        while (ciclo < esp_pr[esp_pr.size() - 1] + 6) espera_ciclo;
        n_ini = 0; n_pro = 0;
        foreach (log1[i]) begin
            if (log1[i].ini === 1'b1) begin
                if (n_ini < esp.size()) begin
                    checks++;
                    if (log1[i].ciclo != esp[n_ini].ciclo || log1[i].bcd !== esp[n_ini].bcd || log1[i].sel !== esp[n_ini].sel) begin
                        errors++;
                        $display("FAIL um_byte_digito%0d: obtido ciclo=%0d bcd=%h sel=%b, esperado ciclo=%0d bcd=%h sel=%b",
                                 n_ini, log1[i].ciclo, log1[i].bcd, log1[i].sel, esp[n_ini].ciclo, esp[n_ini].bcd, esp[n_ini].sel);
                    end
                end
                n_ini++;
            end
            if (log1[i].pro === 1'b1) begin
                if (n_pro < esp_pr.size()) begin
                    checks++;
                    if (log1[i].ciclo != esp_pr[n_pro]) begin
                        errors++;
                        $display("FAIL um_byte_pronto%0d: obtido ciclo %0d esperado %0d", n_pro, log1[i].ciclo, esp_pr[n_pro]);
                    end
                end
                n_pro++;
            end
        end
        checks++;
        if (n_ini != esp.size()) begin errors++; $display("FAIL um_byte_num_inicio: obtido %0d esperado %0d", n_ini, esp.size()); end
        checks++;
        if (n_pro != esp_pr.size()) begin errors++; $display("FAIL um_byte_num_pronto: obtido %0d esperado %0d", n_pro, esp_pr.size()); end
    endtask

    task automatic test_pronto_espurio;
        int n_pulsos, n_estado;
        espera_ciclo;
        log2.delete();
        for (int k = 0; k < 20; k++) begin
            forca2 = (k % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            espera_ciclo;
        end
        forca2 = 1'b0;
        repeat (3) espera_ciclo;
        n_pulsos = 0; n_estado = 0;
        foreach (log2[i]) begin
            if (log2[i].ini !== 1'b0 || log2[i].pro !== 1'b0) n_pulsos++;
            if (log2[i].est !== 4'd0 || log2[i].ocu !== 1'b0) n_estado++;
        end
        checks++;
        if (n_pulsos != 0) begin errors++; $display("FAIL espurio_pulsos: obtido %0d esperado 0", n_pulsos); end
        checks++;
        if (n_estado != 0) begin errors++; $display("FAIL espurio_estado: obtido %0d ciclos fora de INICIAL esperado 0", n_estado); end
    endtask

    initial begin
        reset = 1'b1; partida2 = 1'b0; partida1 = 1'b0;
        dados2 = 16'h0; dados1 = 8'h0; forca2 = 1'b0;
        for (int k = 0; k < 16; k++) atraso2[k] = 1;
        test_reset;
        test_palavras;
        test_reset_meio;
        test_um_byte;
        test_pronto_espurio;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
